sha256_block_sequencer: RTL and testbench

Control and hash-state block for the SHA-256 core. It accepts 512-bit padded message blocks over a valid/ready handshake and holds the intermediate hash H0..H7. For each block it loads the message scheduler and the compression round unit, then steps them through rounds 0..63 and performs the final modular addition into H. After the last block of a message it presents the 256-bit digest until the consumer takes it.

---
 rtl/sha256_block_sequencer.sv | 159 +++++++++++++++
 tb/tb_sha256_block_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_block_sequencer.sv
// SHA-256 block sequencer: accepts padded 512-bit blocks, drives the message
// scheduler and compression round unit through rounds 0..63, folds the
// compressor state into H0..H7 and presents the digest after the last block.
module sha256_block_sequencer (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic [511:0] block_i,
    input  logic         block_v_i,
    input  logic         first_i,
    input  logic         last_i,
    output logic         ready_o,
    output logic [511:0] sched_block_o,
    output logic         sched_init_o,
    output logic         comp_init_o,
    output logic [255:0] hash_o,
    output logic [5:0]   round_o,
    output logic         round_v_o,
    input  logic [255:0] comp_state_i,
    output logic [255:0] digest_o,
    output logic         digest_v_o,
    input  logic         digest_yumi_i
);

    // state | meaning
    // IDLE  | waiting for a block, ready_o high
    // LOAD  | one-cycle load pulse to scheduler and compressor
    // ROUND | compressor runs round round_o, 0..63
    // ADD   | H += compressor state, word by word mod 2^32
    // DONE  | digest valid, held until the consumer takes it
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ROUND = 3'd2,
        ADD   = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    state_t         state_q, state_d;
    logic           last_q, last_d;
    logic [511:0]   block_q, block_d;
    logic [255:0]   hash_q, hash_d;
    logic [5:0]     round_q, round_d;
    logic           ready_q, ready_d;
    logic           sched_init_q, sched_init_d;
    logic           comp_init_q, comp_init_d;
    logic           round_v_q, round_v_d;
    logic           digest_v_q, digest_v_d;

    // Next-state and next-output decode; outputs are computed for the state
    // being entered so that they come straight out of flops.
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        block_d      = block_q;
        hash_d       = hash_q;
        round_d      = round_q;
        ready_d      = 1'b0;
        sched_init_d = 1'b0;
        comp_init_d  = 1'b0;
        round_v_d    = 1'b0;
        digest_v_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (block_v_i) begin
                    block_d      = block_i;
                    last_d       = last_i;
                    if (first_i) begin
                        hash_d = IV;
                    end
                    state_d      = LOAD;
                    sched_init_d = 1'b1;
                    comp_init_d  = 1'b1;
                end else begin
                    ready_d = 1'b1;
                end
            end
            LOAD: begin
                state_d   = ROUND;
                round_d   = 6'd0;
                round_v_d = 1'b1;
            end
            ROUND: begin
                if (round_q == 6'd63) begin
                    state_d = ADD;
                end else begin
                    round_d   = round_q + 6'd1;
                    round_v_d = 1'b1;
                end
            end
            ADD: begin
                for (int i = 0; i < 8; i++) begin
                    hash_d[i*32 +: 32] = hash_q[i*32 +: 32] + comp_state_i[i*32 +: 32];
                end
                if (last_q) begin
                    state_d    = DONE;
                    digest_v_d = 1'b1;
                end else begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
            end
            DONE: begin
                if (digest_yumi_i) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end else begin
                    digest_v_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset back to IDLE and IV.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            last_q       <= 1'b0;
            block_q      <= '0;
            hash_q       <= IV;
            round_q      <= '0;
            ready_q      <= 1'b1;
            sched_init_q <= 1'b0;
            comp_init_q  <= 1'b0;
            round_v_q    <= 1'b0;
            digest_v_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            block_q      <= block_d;
            hash_q       <= hash_d;
            round_q      <= round_d;
            ready_q      <= ready_d;
            sched_init_q <= sched_init_d;
            comp_init_q  <= comp_init_d;
            round_v_q    <= round_v_d;
            digest_v_q   <= digest_v_d;
        end
    end

    assign ready_o       = ready_q;
    assign sched_block_o = block_q;
    assign sched_init_o  = sched_init_q;
    assign comp_init_o   = comp_init_q;
    assign hash_o        = hash_q;
    assign round_o       = round_q;
    assign round_v_o     = round_v_q;
    assign digest_o      = hash_q;
    assign digest_v_o    = digest_v_q;

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Directed bench for sha256_block_sequencer with a behavioural SHA-256
// compressor/scheduler standing in for the datapath.
module tb_sha256_block_sequencer;

    logic         clk_i = 1'b0;
    logic         reset_i = 1'b1;
    logic [511:0] block_i = '0;
    logic         block_v_i = 1'b0;
    logic         first_i = 1'b0;
    logic         last_i = 1'b0;
    logic         ready_o;
    logic [511:0] sched_block_o;
    logic         sched_init_o;
    logic         comp_init_o;
    logic [255:0] hash_o;
    logic [5:0]   round_o;
    logic         round_v_o;
    logic [255:0] comp_state_i;
    logic [255:0] digest_o;
    logic         digest_v_o;
    logic         digest_yumi_i = 1'b0;

    sha256_block_sequencer dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .block_i       (block_i),
        .block_v_i     (block_v_i),
        .first_i       (first_i),
        .last_i        (last_i),
        .ready_o       (ready_o),
        .sched_block_o (sched_block_o),
        .sched_init_o  (sched_init_o),
        .comp_init_o   (comp_init_o),
        .hash_o        (hash_o),
        .round_o       (round_o),
        .round_v_o     (round_v_o),
        .comp_state_i  (comp_state_i),
        .digest_o      (digest_o),
        .digest_v_o    (digest_v_o),
        .digest_yumi_i (digest_yumi_i)
    );

    always #5 clk_i = ~clk_i;

    // Reference compressor and message schedule
    logic [31:0] k_tab [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic [31:0] w_q [0:63];
    logic [31:0] a_q = '0, b_q = '0, c_q = '0, d_q = '0;
    logic [31:0] e_q = '0, f_q = '0, g_q = '0, h_q = '0;
    logic        force_ff = 1'b0;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    always @(posedge clk_i) begin : model
        logic [31:0] wt [0:63];
        logic [31:0] t1, t2;
        if (sched_init_o) begin
            for (int t = 0; t < 16; t++) wt[t] = sched_block_o[511 - 32*t -: 32];
            for (int t = 16; t < 64; t++) begin
                wt[t] = (ror(wt[t-2], 17) ^ ror(wt[t-2], 19) ^ (wt[t-2] >> 10)) + wt[t-7]
                      + (ror(wt[t-15], 7) ^ ror(wt[t-15], 18) ^ (wt[t-15] >> 3)) + wt[t-16];
            end
            w_q <= wt;
        end
        if (comp_init_o) begin
            {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q} <= hash_o;
        end else if (round_v_o) begin
            t1 = h_q + (ror(e_q, 6) ^ ror(e_q, 11) ^ ror(e_q, 25)) + ((e_q & f_q) ^ (~e_q & g_q))
               + k_tab[round_o] + w_q[round_o];
            t2 = (ror(a_q, 2) ^ ror(a_q, 13) ^ ror(a_q, 22)) + ((a_q & b_q) ^ (a_q & c_q) ^ (b_q & c_q));
            h_q <= g_q; g_q <= f_q; f_q <= e_q; e_q <= d_q + t1;
            d_q <= c_q; c_q <= b_q; b_q <= a_q; a_q <= t1 + t2;
        end
    end

    assign comp_state_i = force_ff ? '1 : {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q};

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [255:0] IV_M1 = {
        32'h6a09e666, 32'hbb67ae84, 32'h3c6ef371, 32'ha54ff539,
        32'h510e527e, 32'h9b05688b, 32'h1f83d9aa, 32'h5be0cd18};
    localparam logic [511:0] BLK_ABC = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_2A = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK_2B = {480'h0, 32'h000001c0};
    localparam logic [255:0] DIG_ABC = {
        32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
        32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
    localparam logic [255:0] DIG_2BLK = {
        32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
        32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};

    int n_vec = 0;
    int n_err = 0;
    int si_cnt, ci_cnt, rv_cnt, rerr, blk_err, done_cyc;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one block, then follow it cycle by cycle (cycle 1 = LOAD) until
    // the digest (last) or ready_o (not last) appears, counting pulses.
    task automatic run_block(input logic [511:0] blk, input logic first, input logic last,
                             input logic junk);
        @(negedge clk_i);
        block_i = blk; first_i = first; last_i = last; block_v_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        block_v_i = 1'b0; first_i = 1'b0; last_i = 1'b0;
        si_cnt = 0; ci_cnt = 0; rv_cnt = 0; rerr = 0; blk_err = 0; done_cyc = -1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            if (sched_init_o) si_cnt++;
            if (comp_init_o) ci_cnt++;
            if (round_v_o) begin
                if (round_o !== rv_cnt[5:0]) rerr++;
                rv_cnt++;
            end
            if (sched_block_o !== blk) blk_err++;
            if (junk) begin
                block_v_i = round_v_o; block_i = ~blk; first_i = 1'b1; last_i = 1'b1;
            end
            if (last ? digest_v_o : ready_o) begin
                done_cyc = cyc;
                break;
            end
            @(negedge clk_i);
        end
        block_v_i = 1'b0; first_i = 1'b0; last_i = 1'b0;
    endtask

    initial begin
        int found;
        logic [255:0] held;

        // Reset
        repeat (3) @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);
        check("rst_ready", 512'(ready_o), 512'(1'b1));
        check("rst_hash", 512'(hash_o), 512'(IV));
        check("rst_sched_block", sched_block_o, '0);
        check("rst_round", 512'(round_o), 512'(6'd0));
        check("rst_pulses", 512'({sched_init_o, comp_init_o, round_v_o, digest_v_o}), 512'(4'b0));

        // Single-block "abc" with junk offered during ROUND
        run_block(BLK_ABC, 1'b1, 1'b1, 1'b1);
        check("abc_digest_cycle", 512'(done_cyc), 512'(67));
        check("abc_digest", 512'(digest_o), 512'(DIG_ABC));
        check("abc_hash_eq_digest", 512'(hash_o), 512'(DIG_ABC));
        check("sched_init_cycles", 512'(si_cnt), 512'(1));
        check("comp_init_cycles", 512'(ci_cnt), 512'(1));
        check("round_v_cycles", 512'(rv_cnt), 512'(64));
        check("round_sequence_errs", 512'(rerr), 512'(0));
        check("junk_block_errs", 512'(blk_err), 512'(0));
        check("sched_block_kept", sched_block_o, BLK_ABC);

        // Backpressure: yumi withheld for 10 cycles
        held = digest_o;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            check("bp_digest_v", 512'(digest_v_o), 512'(1'b1));
            check("bp_digest", 512'(digest_o), 512'(held));
            check("bp_ready", 512'(ready_o), 512'(1'b0));
        end
        digest_yumi_i = 1'b1;
        @(negedge clk_i);
        digest_yumi_i = 1'b0;
        check("yumi_ready", 512'(ready_o), 512'(1'b1));
        check("yumi_digest_v", 512'(digest_v_o), 512'(1'b0));
        check("yumi_h_retained", 512'(hash_o), 512'(DIG_ABC));

        // Two-block message, digest taken in the cycle it appears
        run_block(BLK_2A, 1'b1, 1'b0, 1'b0);
        check("blk1_ready_cycle", 512'(done_cyc), 512'(67));
        run_block(BLK_2B, 1'b0, 1'b1, 1'b0);
        check("blk2_digest_cycle", 512'(done_cyc), 512'(67));
        check("two_block_digest", 512'(digest_o), 512'(DIG_2BLK));
        digest_yumi_i = 1'b1;
        @(negedge clk_i);
        digest_yumi_i = 1'b0;
        check("same_cycle_yumi_ready", 512'(ready_o), 512'(1'b1));
        check("same_cycle_yumi_dv", 512'(digest_v_o), 512'(1'b0));

        // Reset in the middle of round 30
        @(negedge clk_i);
        block_i = BLK_ABC; first_i = 1'b0; last_i = 1'b1; block_v_i = 1'b1;
        @(negedge clk_i);
        block_v_i = 1'b0; last_i = 1'b0;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            if (round_v_o && round_o == 6'd30) begin
                found = 1;
                break;
            end
            @(negedge clk_i);
        end
        check("reach_round30", 512'(found), 512'(1));
        reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;
        check("mid_rst_round_v", 512'(round_v_o), 512'(1'b0));
        check("mid_rst_ready", 512'(ready_o), 512'(1'b1));
        check("mid_rst_hash", 512'(hash_o), 512'(IV));
        check("mid_rst_digest_v", 512'(digest_v_o), 512'(1'b0));
        check("mid_rst_sched_block", sched_block_o, '0);

        run_block(BLK_ABC, 1'b0, 1'b1, 1'b0);
        check("post_rst_digest_cycle", 512'(done_cyc), 512'(67));
        check("post_rst_digest", 512'(digest_o), 512'(DIG_ABC));
        digest_yumi_i = 1'b1;
        @(negedge clk_i);
        digest_yumi_i = 1'b0;

        // All-ones compressor state: every Hi becomes IVi - 1
        force_ff = 1'b1;
        run_block(BLK_ABC, 1'b1, 1'b0, 1'b0);
        force_ff = 1'b0;
        check("ff_ready_cycle", 512'(done_cyc), 512'(67));
        check("ff_wrap_hash", 512'(hash_o), 512'(IV_M1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
